// File: rtl/content_grad_update_if.sv
// rtl/content_grad_update_if.sv - frame-pair in / updated frame out handshake bundle for content_grad_update
interface content_grad_update_if #(
  parameter int N_PIX = 64,
  parameter int PIX_W = 16
) ();
  logic                   start_valid;
  logic                   start_ready;
  logic [PIX_W-1:0]       content_weight;
  logic [N_PIX*PIX_W-1:0] content_pixels;
  logic [N_PIX*PIX_W-1:0] generated_pixels;
  logic [N_PIX*PIX_W-1:0] update_pixels;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output start_valid, content_weight, content_pixels, generated_pixels, out_ready,
    input  start_ready, update_pixels, out_valid
  );

  modport slave (
    input  start_valid, content_weight, content_pixels, generated_pixels, out_ready,
    output start_ready, update_pixels, out_valid
  );
endinterface

// File: rtl/content_grad_update.sv
// rtl/content_grad_update.sv - content-loss backward step: new = g - ((g-c)*w >>> (8+LR_SHIFT)), LANES pixels/beat
// Optional: define CONTENT_GRAD_CLAMP_EN to saturate results to [0, 2^PIX_W-1] instead of wrapping.
module content_grad_update #(
  parameter int N_PIX    = 64,
  parameter int PIX_W    = 16,
  parameter int LANES    = 4,
  parameter int LR_SHIFT = 3
) (
  input logic               clk,
  input logic               rst,
  content_grad_update_if.slave bus
);
  localparam int BEATS = N_PIX / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SLICE = LANES * PIX_W;
  localparam int PW2   = 2 * PIX_W + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [BW-1:0]          beat_q;
  logic [N_PIX*PIX_W-1:0] gen_q, cont_q, update_q;
  logic [PIX_W-1:0]       weight_q;
  logic [SLICE-1:0]       lane_bundle;
  logic                   last_beat;
  logic                   accept;

  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign accept    = bus.start_valid & bus.start_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)        state_d = RUN;
      RUN:     if (last_beat)     state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.start_ready = (state_q == IDLE);
    bus.out_valid   = (state_q == DONE);
  end

  // Captured frames shift down one slice per beat so the lanes always read the low bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q   <= '0;
      update_q <= '0;
      gen_q    <= '0;
      cont_q   <= '0;
      weight_q <= '0;
    end else if (accept) begin
      gen_q    <= bus.generated_pixels;
      cont_q   <= bus.content_pixels;
      weight_q <= bus.content_weight;
      beat_q   <= '0;
    end else if (state_q == RUN) begin
      update_q[int'(beat_q) * SLICE +: SLICE] <= lane_bundle;
      gen_q  <= gen_q >> SLICE;
      cont_q <= cont_q >> SLICE;
      beat_q <= last_beat ? '0 : beat_q + 1'b1;
    end
  end

  assign bus.update_pixels = update_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [PIX_W-1:0]      g, c;
    logic signed [PIX_W:0] diff;
    logic signed [PW2-1:0] prod, step;

    assign g    = gen_q[l*PIX_W +: PIX_W];
    assign c    = cont_q[l*PIX_W +: PIX_W];
    assign diff = $signed({1'b0, g}) - $signed({1'b0, c});
    assign prod = $signed({{(PIX_W+1){diff[PIX_W]}}, diff}) * $signed({{(PIX_W+2){1'b0}}, weight_q});
    assign step = prod >>> (8 + LR_SHIFT);
`ifdef CONTENT_GRAD_CLAMP_EN
    logic signed [PW2-1:0] new_full;
    assign new_full = $signed({{(PIX_W+2){1'b0}}, g}) - step;
    assign lane_bundle[l*PIX_W +: PIX_W] = new_full[PW2-1]               ? '0 :
                                           (|new_full[PW2-2:PIX_W])      ? '1 :
                                           new_full[PIX_W-1:0];
`else
    assign lane_bundle[l*PIX_W +: PIX_W] = PIX_W'($signed({{(PIX_W+2){1'b0}}, g}) - step);
`endif
  end
endmodule

// File: tb/tb_content_grad_update.sv
// tb/tb_content_grad_update.sv - scoreboard bench for content_grad_update with an integer reference model
module tb_content_grad_update;
  localparam int NP    = 64;
  localparam int PW    = 16;
  localparam int LN    = 4;
  localparam int BEATS = NP / LN;
  localparam int VW    = NP * PW;

  typedef struct {
    logic [VW-1:0] data;
    int            accept_cyc;
    int            hold;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_release_cyc = -100;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  content_grad_update_if #(.N_PIX(NP), .PIX_W(PW)) bus ();

  content_grad_update #(.N_PIX(NP), .PIX_W(PW), .LANES(LN), .LR_SHIFT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      for (int i = 0; i < NP; i++) begin
        if (act[i*PW +: PW] !== req[i*PW +: PW]) begin
          $display("FAIL %s pixel=%0d actual=%0d required=%0d", nm, i, act[i*PW +: PW], req[i*PW +: PW]);
          break;
        end
      end
    end
  endtask

  // Reference: plain integer arithmetic, learning rate 1/8, weight scaled by 1/256.
  function automatic logic [VW-1:0] model(input logic [VW-1:0] g, input logic [VW-1:0] c, input int w);
    logic [VW-1:0] r;
    longint gi, ci, prod, step, nv;
    for (int i = 0; i < NP; i++) begin
      gi   = longint'(g[i*PW +: PW]);
      ci   = longint'(c[i*PW +: PW]);
      prod = (gi - ci) * longint'(w);
      if (prod >= 0) step = prod / 2048;
      else           step = -((-prod + 2047) / 2048);
      nv = gi - step;
`ifdef CONTENT_GRAD_CLAMP_EN
      if (nv < 0) nv = 0;
      if (nv > 65535) nv = 65535;
`else
      nv = nv & 65535;
`endif
      r[i*PW +: PW] = PW'(nv);
    end
    return r;
  endfunction

  task automatic issue_frame(input logic [VW-1:0] g, input logic [VW-1:0] c, input logic [PW-1:0] w,
                             input logic [VW-1:0] expv, input bit track, input int hold, output int acc_cyc);
    exp_t e;
    int   waited;
    @(negedge clk);
    bus.generated_pixels = g;
    bus.content_pixels   = c;
    bus.content_weight   = w;
    bus.start_valid      = 1'b1;
    waited = 0;
    while (!bus.start_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.start_ready) begin
      chk("accept_timeout", 0, 1);
      bus.start_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    acc_cyc = cyc + 1;
    if (track) begin
      e.data = expv; e.accept_cyc = acc_cyc; e.hold = hold;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start_valid      = 1'b0;
    bus.generated_pixels = {32{$urandom()}};
    bus.content_pixels   = {32{$urandom()}};
    bus.content_weight   = PW'($urandom());
    chk("start_ready_busy", longint'(bus.start_ready), 0);
  endtask

  // Monitor: pops one expectation per presented result, checks latency, data and hold stability.
  initial begin
    exp_t          e;
    logic [VW-1:0] snap;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || !bus.out_valid) begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end else if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
      end else begin
        e = sb.pop_front();
        bus.out_ready = (e.hold == 0);
        chk("latency", longint'(cyc - e.accept_cyc), BEATS);
        chk_vec("update_pixels", bus.update_pixels, e.data);
        snap = bus.update_pixels;
        for (int h = 0; h < e.hold; h++) begin
          @(negedge clk);
          chk("hold_valid", longint'(bus.out_valid), 1);
          chk_vec("hold_data", bus.update_pixels, snap);
        end
        bus.out_ready = 1'b1;
        last_release_cyc = cyc + 1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("out_valid_drop", longint'(bus.out_valid), 0);
      end
    end
  end

  initial begin
    logic [VW-1:0] g, c, ex;
    logic [PW-1:0] w;
    int            acc, acc2, waited;

    rst = 1'b1;
    bus.start_valid = 1'b0;
    bus.generated_pixels = '0;
    bus.content_pixels = '0;
    bus.content_weight = '0;
    repeat (3) @(negedge clk);
    chk("reset_start_ready", longint'(bus.start_ready), 1);
    chk("reset_out_valid", longint'(bus.out_valid), 0);
    chk_vec("reset_update", bus.update_pixels, '0);
    rst = 1'b0;

    // Equal frames leave pixels unchanged.
    for (int i = 0; i < NP; i++) begin
      g[i*PW +: PW] = 16'd100; c[i*PW +: PW] = 16'd100; ex[i*PW +: PW] = 16'd100;
    end
    issue_frame(g, c, 16'h0100, ex, 1'b1, 0, acc);

    // Positive step and negative fractional step (floors to -1).
    for (int i = 0; i < NP; i++) begin
      if (i < NP / 2) begin g[i*PW +: PW] = 16'd1000; c[i*PW +: PW] = 16'd200; ex[i*PW +: PW] = 16'd900; end
      else            begin g[i*PW +: PW] = 16'd0;    c[i*PW +: PW] = 16'd3;   ex[i*PW +: PW] = 16'd1;   end
    end
    issue_frame(g, c, 16'h0100, ex, 1'b1, 0, acc);

    // Extreme over/underflow at maximum weight.
    for (int i = 0; i < NP; i++) begin
      if (i[0]) begin
        g[i*PW +: PW] = 16'd0; c[i*PW +: PW] = 16'hFFFF;
`ifdef CONTENT_GRAD_CLAMP_EN
        ex[i*PW +: PW] = 16'd65535;
`else
        ex[i*PW +: PW] = 16'd57313;
`endif
      end else begin
        g[i*PW +: PW] = 16'hFFFF; c[i*PW +: PW] = 16'd0;
`ifdef CONTENT_GRAD_CLAMP_EN
        ex[i*PW +: PW] = 16'd0;
`else
        ex[i*PW +: PW] = 16'd8223;
`endif
      end
    end
    issue_frame(g, c, 16'hFF00, ex, 1'b1, 0, acc);

    // Backpressure for 10 cycles, then a start held high across the release.
    g = {32{$urandom()}}; c = {32{$urandom()}}; w = PW'($urandom());
    issue_frame(g, c, w, model(g, c, int'(w)), 1'b1, 10, acc);
    g = {32{$urandom()}}; c = {32{$urandom()}}; w = PW'($urandom());
    issue_frame(g, c, w, model(g, c, int'(w)), 1'b1, 0, acc2);
    chk("accept_after_release", longint'(acc2), longint'(last_release_cyc + 1));

    // Zero weight is an identity update.
    g = {32{$urandom()}}; c = {32{$urandom()}};
    issue_frame(g, c, 16'h0000, g, 1'b1, 1, acc);

    // Reset landing on beat 7 aborts the frame.
    g = {32{$urandom()}}; c = {32{$urandom()}}; w = PW'($urandom());
    issue_frame(g, c, w, '0, 1'b0, 0, acc);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_start_ready", longint'(bus.start_ready), 1);
    chk("abort_out_valid", longint'(bus.out_valid), 0);
    chk_vec("abort_update", bus.update_pixels, '0);
    rst = 1'b0;

    for (int n = 0; n < 10; n++) begin
      g = {32{$urandom()}}; c = {32{$urandom()}};
      w = (n == 3) ? 16'hFFFF : PW'($urandom());
      issue_frame(g, c, w, model(g, c, int'(w)), 1'b1, int'($urandom_range(0, 3)), acc);
    end

    waited = 0;
    while ((sb.size() != 0 || bus.out_valid) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_pending", longint'(sb.size()), 0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
